// File: rtl/gray_burst_pkg.sv
// Shared types and helpers for the Gray-coded burst sequencer.
// Helpers operate on a 32-bit container; callers zero-extend and truncate to their width.
package gray_burst_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned FN_W = 32;

  // Zero-extension does not disturb the low bits of a Gray image, so any width up to FN_W works.
  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic int unsigned popcount(input logic [FN_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(FN_W); i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_step.sv
// Registered binary counter with its Gray image; clear-to-zero has priority over a step.
module gray_step #(
  parameter int BIT_SIZE = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_zero,
  input  logic                step_en,
  input  logic [BIT_SIZE-1:0] inc,
  output logic [BIT_SIZE-1:0] gray,
  output logic [BIT_SIZE-1:0] gray_next
);
  import gray_burst_pkg::*;

  logic [BIT_SIZE-1:0] bin_p0;
  logic [BIT_SIZE-1:0] bin_next;

  assign bin_next  = bin_p0 + inc;
  assign gray_next = BIT_SIZE'(bin2gray(32'(bin_next)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bin_p0 <= '0;
      gray   <= '0;
    end else if (load_zero) begin
      bin_p0 <= '0;
      gray   <= '0;
    end else if (step_en) begin
      bin_p0 <= bin_next;
      gray   <= gray_next;
    end
  end

endmodule

// File: rtl/gray_burst_ctrl.sv
// Burst sequencer driving a Gray-coded counter over a valid/ready command port.
// Optional Gray single-bit-step checker enabled by defining GRAY_BURST_CHK_EN.
module gray_burst_ctrl #(
  parameter int BIT_SIZE = 4,
  parameter int LEN_W    = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [LEN_W-1:0]    cmd_len_i,
  input  logic [BIT_SIZE-1:0] cmd_inc_i,
  input  logic                cmd_clr_i,
  input  logic                abort_i,
  output logic [BIT_SIZE-1:0] cnt_o,
  output logic                cnt_valid_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);
  import gray_burst_pkg::*;

  state_t              state_p0;
  state_t              state_nxt;
  logic                accept;
  logic                step;
  logic                abort_run;
  logic                last_step;
  logic [LEN_W-1:0]    remaining_p0;
  logic [BIT_SIZE-1:0] inc_p0;
  logic                vld_p1;
  logic                done_p1;
  logic [BIT_SIZE-1:0] gray_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_p0 <= IDLE;
    else       state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE: if (cmd_valid_i) state_nxt = (cmd_len_i == '0) ? DONE : RUN;
      RUN:  if (abort_i || remaining_p0 == LEN_W'(1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Abort beats a step: an aborted edge neither advances the counter nor flags valid.
  always_comb begin
    cmd_ready_o = 1'b0;
    busy_o      = 1'b1;
    accept      = 1'b0;
    step        = 1'b0;
    abort_run   = 1'b0;
    last_step   = 1'b0;
    case (state_p0)
      IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        accept      = cmd_valid_i;
      end
      RUN: begin
        abort_run = abort_i;
        step      = ~abort_i;
        last_step = ~abort_i && (remaining_p0 == LEN_W'(1));
      end
      default: ;
    endcase
  end

  // ---- stage p1: registered burst status and length bookkeeping ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      remaining_p0 <= '0;
      inc_p0       <= '0;
      vld_p1       <= 1'b0;
      done_p1      <= 1'b0;
    end else begin
      vld_p1  <= step;
      done_p1 <= (accept && cmd_len_i == '0) || abort_run || last_step;
      if (accept) begin
        remaining_p0 <= cmd_len_i;
        inc_p0       <= cmd_inc_i;
      end else if (step) begin
        remaining_p0 <= remaining_p0 - LEN_W'(1);
      end
    end
  end

  assign cnt_valid_o = vld_p1;
  assign done_o      = done_p1;

  gray_step #(
    .BIT_SIZE (BIT_SIZE)
  ) u_step (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_zero (accept & cmd_clr_i),
    .step_en   (step),
    .inc       (inc_p0),
    .gray      (cnt_o),
    .gray_next (gray_next)
  );

`ifdef GRAY_BURST_CHK_EN
  logic err_p1;

  // With a unit increment every step must flip exactly one Gray bit; wrap included.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_p1 <= 1'b0;
    end else if (step && inc_p0 == BIT_SIZE'(1) &&
                 popcount(32'(cnt_o ^ gray_next)) != 32'd1) begin
      err_p1 <= 1'b1;
    end
  end

  assign err_o = err_p1;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gray_burst_ctrl.sv
// Directed bench for gray_burst_ctrl with a scoreboard of expected Gray values.
module tb_gray_burst_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [7:0] cmd_len_i;
  logic [3:0] cmd_inc_i;
  logic       cmd_clr_i;
  logic       abort_i;
  logic [3:0] cnt_o;
  logic       cnt_valid_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  gray_burst_ctrl #(.BIT_SIZE(4), .LEN_W(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_len_i   (cmd_len_i),
    .cmd_inc_i   (cmd_inc_i),
    .cmd_clr_i   (cmd_clr_i),
    .abort_i     (abort_i),
    .cnt_o       (cnt_o),
    .cnt_valid_o (cnt_valid_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int         pass_cnt = 0;
  int         fail_cnt = 0;
  int         total_cnt = 0;
  int         cyc = 0;
  int         vld_pulses = 0;
  int         done_pulses = 0;
  int         last_vld_cyc = 0;
  int         last_done_cyc = 0;
  logic [3:0] mbin = 4'd0;
  logic [3:0] exp_q[$];

  function automatic logic [3:0] g4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; samples 1 time unit after the edge and drains the scoreboard on valid.
  task automatic tick();
    logic [3:0] e;
    @(posedge clk_i);
    #1;
    cyc++;
    if (cnt_valid_o) begin
      vld_pulses++;
      last_vld_cyc = cyc;
      if (exp_q.size() == 0) chk("sb_underflow_valid", 32'(cnt_valid_o), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("cnt_o_step", 32'(cnt_o), 32'(e));
      end
    end
    if (done_o) begin
      done_pulses++;
      last_done_cyc = cyc;
    end
  endtask

  task automatic clear_stats();
    vld_pulses  = 0;
    done_pulses = 0;
  endtask

  task automatic push_burst(input int len, input logic [3:0] inc, input logic clr);
    if (clr) mbin = 4'd0;
    for (int i = 0; i < len; i++) begin
      mbin = mbin + inc;
      exp_q.push_back(g4(mbin));
    end
  endtask

  task automatic wait_ready(output int n);
    n = 1;
    while (!cmd_ready_o && n < 50) begin
      tick();
      if (!cmd_ready_o) n++;
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy_o && g < 300) begin
      tick();
      g++;
    end
    chk("idle_wait", 32'(busy_o), 32'd0);
  endtask

  task automatic send(input int len, input logic [3:0] inc, input logic clr);
    int g;
    cmd_len_i   = 8'(len);
    cmd_inc_i   = inc;
    cmd_clr_i   = clr;
    cmd_valid_i = 1'b1;
    g = 0;
    while (!cmd_ready_o && g < 100) begin
      tick();
      g++;
    end
    chk("ready_wait", 32'(cmd_ready_o), 32'd1);
    push_burst(len, inc, clr);
    tick();
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic [3:0] fv;
    rst_i       = 1'b1;
    cmd_valid_i = 1'b1;
    cmd_len_i   = 8'd5;
    cmd_inc_i   = 4'd1;
    cmd_clr_i   = 1'b1;
    abort_i     = 1'b0;
    fv          = 4'd0;

    // Reset held with a command offered
    tick();
    tick();
    chk("rst_cnt_o", 32'(cnt_o), 32'd0);
    chk("rst_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_valid", 32'(cnt_valid_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_no_step", 32'(vld_pulses), 32'd0);

    // Release: pending len=5 inc=1 clr=1 command taken on the next edge
    push_burst(5, 4'd1, 1'b1);
    clear_stats();
    rst_i = 1'b0;
    tick();
    chk("accept_busy", 32'(busy_o), 32'd1);
    chk("accept_ready", 32'(cmd_ready_o), 32'd0);
    cmd_valid_i = 1'b0;
    wait_ready(n);
    chk("b5_ready_low_cycles", 32'(n), 32'd6);
    chk("b5_valid_count", 32'(vld_pulses), 32'd5);
    chk("b5_done_count", 32'(done_pulses), 32'd1);
    chk("b5_done_with_last", 32'(last_done_cyc), 32'(last_vld_cyc));
    chk("b5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Continue without clear across the wrap, then inc=3 from zero
    clear_stats();
    send(12, 4'd1, 1'b0);
    wait_idle();
    chk("b12_valid_count", 32'(vld_pulses), 32'd12);
    chk("b12_final_cnt", 32'(cnt_o), 32'b0001);
    chk("b12_sb_empty", 32'(exp_q.size()), 32'd0);
    clear_stats();
    send(6, 4'd3, 1'b1);
    wait_idle();
    chk("inc3_valid_count", 32'(vld_pulses), 32'd6);
    chk("inc3_final_cnt", 32'(cnt_o), 32'b0011);

    // Zero-length burst
    tick();
    clear_stats();
    send(0, 4'd1, 1'b0);
    chk("len0_done", 32'(done_o), 32'd1);
    chk("len0_valid", 32'(cnt_valid_o), 32'd0);
    tick();
    chk("len0_done_drop", 32'(done_o), 32'd0);
    chk("len0_ready", 32'(cmd_ready_o), 32'd1);
    chk("len0_cnt_hold", 32'(cnt_o), 32'b0011);
    chk("len0_valid_count", 32'(vld_pulses), 32'd0);

    // Command held valid through a running burst waits for IDLE
    clear_stats();
    cmd_len_i   = 8'd3;
    cmd_inc_i   = 4'd1;
    cmd_clr_i   = 1'b1;
    cmd_valid_i = 1'b1;
    push_burst(3, 4'd1, 1'b1);
    push_burst(2, 4'd2, 1'b0);
    tick();
    cmd_len_i = 8'd2;
    cmd_inc_i = 4'd2;
    cmd_clr_i = 1'b0;
    wait_ready(n);
    chk("held_ready_low_cycles", 32'(n), 32'd4);
    chk("held_first_valids", 32'(vld_pulses), 32'd3);
    tick();
    cmd_valid_i = 1'b0;
    chk("held_accepted", 32'(busy_o), 32'd1);
    wait_idle();
    chk("held_valid_count", 32'(vld_pulses), 32'd5);
    chk("held_done_count", 32'(done_pulses), 32'd2);
    chk("held_final_cnt", 32'(cnt_o), 32'b0100);

    // Abort one cycle after the second step
    clear_stats();
    cmd_len_i   = 8'd10;
    cmd_inc_i   = 4'd1;
    cmd_clr_i   = 1'b1;
    cmd_valid_i = 1'b1;
    push_burst(2, 4'd1, 1'b1);
    tick();
    cmd_valid_i = 1'b0;
    tick();
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_done", 32'(done_o), 32'd1);
    chk("abort_no_valid", 32'(cnt_valid_o), 32'd0);
    chk("abort_cnt_hold", 32'(cnt_o), 32'b0011);
    tick();
    chk("abort_back_idle", 32'(cmd_ready_o), 32'd1);
    chk("abort_valid_count", 32'(vld_pulses), 32'd2);
    chk("abort_sb_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of a burst
    clear_stats();
    send(10, 4'd1, 1'b1);
    tick();
    tick();
    chk("mid_run_busy", 32'(busy_o), 32'd1);
    chk("mid_run_valid", 32'(cnt_valid_o), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_cnt_o", 32'(cnt_o), 32'd0);
    chk("arst_valid", 32'(cnt_valid_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_ready", 32'(cmd_ready_o), 32'd1);
    chk("arst_done", 32'(done_o), 32'd0);
    exp_q.delete();
    mbin = 4'd0;
    #3;
    rst_i = 1'b0;
    tick();
    chk("post_arst_idle", 32'(busy_o), 32'd0);

`ifdef GRAY_BURST_CHK_EN
    // Corrupt the visible count across one unit step
    clear_stats();
    send(8, 4'd1, 1'b1);
    tick();
    fv = ~cnt_o;
    force dut.cnt_o = fv;
    @(posedge clk_i);
    #1;
    release dut.cnt_o;
    void'(exp_q.pop_front());
    wait_idle();
    chk("chk_err_set", 32'(err_o), 32'd1);
    tick();
    chk("chk_err_sticky", 32'(err_o), 32'd1);
`else
    chk("err_tied_low", 32'(err_o), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
